spot_finder_mem_writer: RTL and testbench
=========================================

Name: spot_finder_mem_writer

Overview:
- Write side of the spot finder block RAM.
- Accepts the camera's serial 8-bit pixel stream and packs 32 consecutive pixels into one 256-bit kernel word. Each word is written to the RAM at sequential addresses, starting at 0 for every frame.
- When a whole frame (cam_kernels_x * cam_lines_y words) is stored, the block raises frame_done. The RAM then belongs to the analysis side until it releases the buffer with frame_release.

Parameters:
- mem_depth, 16384, number of 256-bit words in the spot finder RAM; the largest legal frame size in words.
- pixels_per_kernel, 32, pixels per RAM word; fixed, and must match the 256-bit data width.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_start  input  1  one-cycle pulse; the first pixel of a new frame follows in the same cycle or later.
- pixel_data  input  8  pixel brightness value.
- pixel_valid  input  1  pixel_data is valid this cycle.
- cam_kernels_x  input  16  kernels per line; line width / 32.
- cam_lines_y  input  16  lines per frame.
- frame_release  input  1  pulse from the analysis side; the buffer may be overwritten.
- mem_address  output  14  RAM write address.
- mem_data  output  256  RAM write data; pixel n of the kernel is in bits [8n+7:8n], pixel 0 is leftmost.
- mem_we  output  1  RAM write enable; one-cycle pulse per word.
- frame_done  output  1  level; a complete frame is stored and not yet released.
- frame_aborted  output  1  one-cycle pulse; the current frame was abandoned by a new frame_start.
- overflow  output  1  sticky; a pixel arrived while no frame was accepting pixels.
- cfg_err  output  1  sticky; the latched frame size is illegal.

Behaviour:
- Reset values: all outputs 0; state IDLE; pixel counter 0; word counter 0; latched dimensions 0.
- Dimension latch: at every accepted frame_start, latch cam_kernels_x and cam_lines_y, and compute total_words = kx * ly (32-bit product).
  - Legal: 1 <= total_words <= mem_depth.
  - Illegal: set cfg_err, return to IDLE, store nothing.
  - cfg_err clears at the next legal frame_start.
- States:
  - IDLE: waits for frame_start, then goes to FILL. pixel_valid while in IDLE sets overflow and the pixel is dropped.
  - FILL: each pixel with pixel_valid=1 is written into byte slot pix_cnt of the packing register, then pix_cnt increments (5-bit counter).
    - When pix_cnt == 31 and a pixel is accepted, the completed word is registered onto mem_data and mem_address=word_cnt.
    - mem_we=1 in the next cycle, for exactly one cycle.
    - word_cnt increments and pix_cnt wraps to 0.
    - Write latency: 1 cycle from acceptance of the 32nd pixel to mem_we.
  - FILL to DONE: when the written word is number total_words - 1. frame_done=1 in the same cycle as that last mem_we.
  - DONE: frame_done held at 1 and pixels ignored. pixel_valid sets overflow.
    - frame_release returns the block to IDLE and clears frame_done on the next edge.
    - frame_start in DONE is ignored until released and sets overflow.
- Simultaneous events:
  - frame_start with pixel_valid in the same cycle: the pixel becomes pixel 0 of the new frame.
  - frame_start during FILL: frame_aborted pulses, pix_cnt and word_cnt reset to 0, dimensions re-latched, and the state stays in FILL. A partial word is discarded, never written.
  - frame_release outside DONE is ignored.
- overflow clears at the next frame_start accepted in IDLE or FILL.
- Width rules:
  - mem_address is the low 14 bits of word_cnt. The legality check guarantees it never wraps inside a frame.
  - Unused packing bytes of an aborted word are never driven to the RAM.
- Reset mid-frame: everything returns to reset values immediately, asynchronously. A pending mem_we is cancelled.

Test Plan:
- Basic frame: kx=2, ly=2, frame_start, then 128 pixels with values 0..127 on consecutive cycles.
  - Expect 4 mem_we pulses at addresses 0,1,2,3.
  - Word 0 bytes: byte0=0x00, byte31=0x1F. Word 3: byte0=0x60, byte31=0x7F.
  - frame_done rises together with the 4th mem_we.
- Gapped stream: same frame with pixel_valid toggling 1/0 → identical words and addresses; each mem_we exactly 1 cycle after the 32nd accepted pixel.
- Abort: kx=2, ly=2; frame_start, 40 pixels, then frame_start.
  - Expect a frame_aborted pulse; no write of the 8-pixel partial word.
  - The next 128 pixels are written at addresses 0..3.
- Hold/release: after frame_done, send 10 pixels and a frame_start.
  - Expect no mem_we and overflow=1.
  - Then frame_release: frame_done=0 and state IDLE. A new frame_start clears overflow.
- Config error: kx=0, ly=5 → cfg_err=1, no writes. kx=20, ly=820 (16400 > 16384) → cfg_err=1. kx=20, ly=480 (9600 words) → cfg_err clears, last write at address 9599.
- Async reset: assert reset after 3 words mid-frame → all outputs 0 before the next clock edge. A following frame starts at address 0.

Source files
------------

// File: rtl/spot_finder_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : spot_finder_mem_writer
// Description : Write side of the spot finder block RAM. Packs the serial
//               8-bit camera pixel stream into 256-bit kernel words, writes
//               them to sequential RAM addresses from 0 for each frame, and
//               holds the finished frame until the analysis side releases it.
// Revision    : 1.0 - initial release
// ============================================================================
module spot_finder_mem_writer #(
    parameter int MEM_DEPTH         = 16384,
    parameter int PIXELS_PER_KERNEL = 32
) (
    input  logic                               clk_in,
    input  logic                               reset,
    input  logic                               frame_start,
    input  logic [7:0]                         pixel_data,
    input  logic                               pixel_valid,
    input  logic [15:0]                        cam_kernels_x,
    input  logic [15:0]                        cam_lines_y,
    input  logic                               frame_release,
    output logic [$clog2(MEM_DEPTH)-1:0]       mem_address,
    output logic [PIXELS_PER_KERNEL*8-1:0]     mem_data,
    output logic                               mem_we,
    output logic                               frame_done,
    output logic                               frame_aborted,
    output logic                               overflow,
    output logic                               cfg_err
);

    localparam int                 c_ADDR_W    = $clog2(MEM_DEPTH);
    localparam int                 c_PIX_W     = $clog2(PIXELS_PER_KERNEL);
    localparam logic [c_PIX_W-1:0] c_LAST_PIX  = c_PIX_W'(PIXELS_PER_KERNEL - 1);
    localparam logic [31:0]        c_MAX_WORDS = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Latched frame geometry and position within the frame
    logic [15:0]          r_kx;
    logic [15:0]          r_ly;
    logic [15:0]          r_col_cnt;
    logic [15:0]          r_row_cnt;
    logic [c_PIX_W-1:0]   r_pix_cnt;
    logic [c_ADDR_W-1:0]  r_word_cnt;

    // Packing register: byte n holds pixel n of the kernel being assembled
    logic [PIXELS_PER_KERNEL-1:0][7:0] r_pack;
    logic [PIXELS_PER_KERNEL-1:0][7:0] w_pack_next;
    logic [c_PIX_W-1:0]                w_slot;

    // Frame size evaluated on the live camera inputs at frame_start
    logic [31:0] w_total_words;
    logic        w_size_legal;

    // FSM control strobes
    logic w_start_accept;
    logic w_abort;
    logic w_take_pixel;
    logic w_word_done;
    logic w_set_overflow;
    logic w_last_col;
    logic w_last_row;

    assign w_total_words = {16'd0, cam_kernels_x} * {16'd0, cam_lines_y};
    assign w_size_legal  = (w_total_words != 32'd0) && (w_total_words <= c_MAX_WORDS);

    // Frame end is tracked as (column, line) of kernels so the latched
    // dimensions are used directly and no multiplier sits in the write path.
    assign w_last_col = (r_col_cnt == r_kx - 16'd1);
    assign w_last_row = (r_row_cnt == r_ly - 16'd1);

    assign frame_done = (r_state == ST_DONE);

    // State register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        w_state_next   = r_state;
        w_start_accept = 1'b0;
        w_abort        = 1'b0;
        w_take_pixel   = 1'b0;
        w_word_done    = 1'b0;
        w_set_overflow = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (frame_start) begin
                    w_start_accept = 1'b1;
                    w_take_pixel   = w_size_legal && pixel_valid;
                    w_state_next   = w_size_legal ? ST_FILL : ST_IDLE;
                end else if (pixel_valid) begin
                    w_set_overflow = 1'b1;
                end
            end

            ST_FILL: begin
                if (frame_start) begin
                    // Restart: the partial word is simply never written
                    w_start_accept = 1'b1;
                    w_abort        = 1'b1;
                    w_take_pixel   = w_size_legal && pixel_valid;
                    w_state_next   = w_size_legal ? ST_FILL : ST_IDLE;
                end else if (pixel_valid) begin
                    w_take_pixel = 1'b1;
                    if (r_pix_cnt == c_LAST_PIX) begin
                        w_word_done = 1'b1;
                        if (w_last_col && w_last_row) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                // Buffer belongs to the analysis side; anything arriving is lost
                if (frame_start || pixel_valid) begin
                    w_set_overflow = 1'b1;
                end
                if (frame_release) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Insert the incoming pixel into its byte slot; a new frame restarts at slot 0
    always_comb begin
        w_slot         = w_start_accept ? '0 : r_pix_cnt;
        w_pack_next    = r_pack;
        w_pack_next[w_slot] = pixel_data;
    end

    // Pixel packing register
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_pack <= '0;
        end else if (w_take_pixel) begin
            r_pack <= w_pack_next;
        end
    end

    // Frame geometry latch and pixel/word/position counters
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_kx       <= '0;
            r_ly       <= '0;
            r_pix_cnt  <= '0;
            r_word_cnt <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
        end else if (w_start_accept) begin
            r_kx       <= cam_kernels_x;
            r_ly       <= cam_lines_y;
            r_pix_cnt  <= w_take_pixel ? c_PIX_W'(1) : '0;
            r_word_cnt <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
        end else if (w_take_pixel) begin
            r_pix_cnt <= r_pix_cnt + c_PIX_W'(1);
            if (w_word_done) begin
                r_word_cnt <= r_word_cnt + c_ADDR_W'(1);
                if (w_last_col) begin
                    r_col_cnt <= '0;
                    r_row_cnt <= r_row_cnt + 16'd1;
                end else begin
                    r_col_cnt <= r_col_cnt + 16'd1;
                end
            end
        end
    end

    // RAM write port: completed word registered, write enable one cycle later
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mem_we      <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
        end else begin
            mem_we <= w_word_done;
            if (w_word_done) begin
                mem_address <= r_word_cnt;
                mem_data    <= w_pack_next;
            end
        end
    end

    // Status flags: abort pulse, sticky overflow and configuration error
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            frame_aborted <= 1'b0;
            overflow      <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            frame_aborted <= w_abort;
            if (w_start_accept) begin
                overflow <= 1'b0;
                cfg_err  <= ~w_size_legal;
            end else if (w_set_overflow) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spot_finder_mem_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spot_finder_mem_writer
// Description : Self-checking bench for spot_finder_mem_writer. A frame-level
//               reference model (pixel queue, word count, status flags) runs
//               alongside the DUT and every cycle's outputs are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spot_finder_mem_writer;

    logic         clk_in = 1'b0;
    logic         reset = 1'b1;
    logic         frame_start = 1'b0;
    logic [7:0]   pixel_data = 8'd0;
    logic         pixel_valid = 1'b0;
    logic [15:0]  cam_kernels_x = 16'd0;
    logic [15:0]  cam_lines_y = 16'd0;
    logic         frame_release = 1'b0;
    logic [13:0]  mem_address;
    logic [255:0] mem_data;
    logic         mem_we;
    logic         frame_done;
    logic         frame_aborted;
    logic         overflow;
    logic         cfg_err;

    spot_finder_mem_writer dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .frame_start   (frame_start),
        .pixel_data    (pixel_data),
        .pixel_valid   (pixel_valid),
        .cam_kernels_x (cam_kernels_x),
        .cam_lines_y   (cam_lines_y),
        .frame_release (frame_release),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_we        (mem_we),
        .frame_done    (frame_done),
        .frame_aborted (frame_aborted),
        .overflow      (overflow),
        .cfg_err       (cfg_err)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model
    bit         m_active = 1'b0;   // a legal frame is accepting pixels
    bit         m_done   = 1'b0;   // frame complete, awaiting release
    bit         m_ovf    = 1'b0;
    bit         m_cfg    = 1'b0;
    longint     m_total  = 0;
    int         m_words  = 0;
    logic [7:0] m_px[$];
    int         n_writes = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"},    256'(mem_address),   256'd0);
        chk({tag, "_data"},    mem_data,            256'd0);
        chk({tag, "_we"},      256'(mem_we),        256'd0);
        chk({tag, "_done"},    256'(frame_done),    256'd0);
        chk({tag, "_aborted"}, 256'(frame_aborted), 256'd0);
        chk({tag, "_ovf"},     256'(overflow),      256'd0);
        chk({tag, "_cfg"},     256'(cfg_err),       256'd0);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_ovf    = 1'b0;
        m_cfg    = 1'b0;
        m_total  = 0;
        m_words  = 0;
        m_px.delete();
    endtask

    // Apply one cycle of inputs, advance the model, then check every output
    task automatic step(input bit st, input bit pv, input logic [7:0] d, input bit rel);
        bit           exp_we;
        bit           exp_abort;
        logic [13:0]  exp_addr;
        logic [255:0] exp_data;
        exp_we    = 1'b0;
        exp_abort = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;

        frame_start   = st;
        pixel_valid   = pv;
        pixel_data    = d;
        frame_release = rel;

        if (st && !m_done) begin
            exp_abort = m_active;
            m_total   = longint'(cam_kernels_x) * longint'(cam_lines_y);
            m_cfg     = !(m_total >= 1 && m_total <= 16384);
            m_active  = !m_cfg;
            m_ovf     = 1'b0;
            m_words   = 0;
            m_px.delete();
            if (m_active && pv) m_px.push_back(d);
        end else if (m_done) begin
            if (st || pv) m_ovf = 1'b1;
            if (rel) m_done = 1'b0;
        end else if (m_active) begin
            if (pv) begin
                m_px.push_back(d);
                if (m_px.size() == 32) begin
                    exp_we   = 1'b1;
                    exp_addr = 14'(m_words);
                    for (int i = 0; i < 32; i++) exp_data[8*i +: 8] = m_px[i];
                    m_px.delete();
                    m_words++;
                    if (longint'(m_words) == m_total) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end
            end
        end else if (pv) begin
            m_ovf = 1'b1;
        end

        @(posedge clk_in);
        #1;
        frame_start   = 1'b0;
        pixel_valid   = 1'b0;
        frame_release = 1'b0;

        chk("mem_we",        256'(mem_we),        256'(exp_we));
        chk("frame_done",    256'(frame_done),    256'(m_done));
        chk("frame_aborted", 256'(frame_aborted), 256'(exp_abort));
        chk("overflow",      256'(overflow),      256'(m_ovf));
        chk("cfg_err",       256'(cfg_err),       256'(m_cfg));
        if (exp_we) begin
            n_writes++;
            chk("mem_address", 256'(mem_address), 256'(exp_addr));
            chk("mem_data",    mem_data,          exp_data);
        end
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_in);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        model_reset();

        // Basic frame: 2x2 kernels, pixels 0..127 back to back
        cam_kernels_x = 16'd2;
        cam_lines_y   = 16'd2;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 128; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        chk("basic_write_count", 256'(n_writes), 256'd4);

        // Hold: pixels and frame_start are refused while the buffer is held
        send_pixels(10);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0);

        // Gapped stream; frame_start carries pixel 0 and clears overflow
        step(1'b1, 1'b1, 8'd0, 1'b0);
        for (int i = 1; i < 128; i++) begin
            step(1'b0, 1'b0, 8'hAA, 1'b0);
            step(1'b0, 1'b1, 8'(i), 1'b0);
        end
        step(1'b0, 1'b0, 8'd0, 1'b1);

        // Abort after 40 pixels; a stray release mid-frame has no effect
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(40);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(128);
        step(1'b0, 1'b0, 8'd0, 1'b1);

        // Abort coinciding with what would have been the 32nd pixel
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(31);
        step(1'b1, 1'b1, 8'($urandom), 1'b0);
        send_pixels(127);
        step(1'b0, 1'b0, 8'd0, 1'b1);

        // Randomised small frames with random gaps
        for (int f = 0; f < 4; f++) begin
            int guard;
            guard = 0;
            cam_kernels_x = 16'($urandom_range(1, 3));
            cam_lines_y   = 16'($urandom_range(1, 3));
            step(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
            while (!m_done && guard < 2000) begin
                step(1'b0, ($urandom_range(0, 3) != 0), 8'($urandom), 1'b0);
                guard++;
            end
            chk("rand_frame_done", 256'(frame_done), 256'd1);
            step(1'b0, 1'b0, 8'd0, 1'b1);
        end

        // Configuration errors and size boundaries
        cam_kernels_x = 16'd0;
        cam_lines_y   = 16'd5;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(40);
        cam_kernels_x = 16'd20;
        cam_lines_y   = 16'd820;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        cam_kernels_x = 16'hFFFF;
        cam_lines_y   = 16'hFFFF;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        cam_kernels_x = 16'd128;
        cam_lines_y   = 16'd128;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(64);
        cam_kernels_x = 16'd1;
        cam_lines_y   = 16'd16385;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(8);
        cam_kernels_x = 16'd20;
        cam_lines_y   = 16'd480;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(96);

        // Asynchronous reset while the third write is on the bus
        chk("pre_reset_we", 256'(mem_we), 256'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        @(posedge clk_in);
        #1;
        reset = 1'b0;
        model_reset();

        // A frame after reset starts again at address 0
        cam_kernels_x = 16'd2;
        cam_lines_y   = 16'd2;
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pixels(128);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
